tpiu_tx: RTL

Transmit-side TPIU formatter/serialiser: accepts complete 16-byte TPIU frames on a 128-bit handshake and drives them onto a 1-, 2- or 4-bit DDR trace port. It inserts full syncs (FF FF FF 7F) at start-up and periodically, and halfsyncs (FF 7F) when idle. It is the mirror of the trace receive path (traceIF + packBuild) and serves as a loopback stimulus source and as a trace replay target. One `clk` cycle is one trace-clock period. The external DDR output cell launches `traceDouta` on the rising edge and `traceDoutb` on the falling edge.

---
 rtl/tpiu_pkg.sv | 29 ++
 rtl/tpiu_tx_shifter.sv | 60 ++++++
 rtl/tpiu_tx.sv | 113 +++++++++++
 3 files changed

// File: rtl/tpiu_pkg.sv
// Shared constants for the TPIU transmit formatter: sync words, width codes, unit kinds.
package tpiu_pkg;

  localparam int unsigned FRAME_W = 128;
  localparam int unsigned REM_W   = 8;

  localparam logic [31:0] FSYNC_WORD = 32'h7FFF_FFFF;
  localparam logic [15:0] HSYNC_WORD = 16'h7FFF;

  localparam logic [1:0] W4 = 2'd3;
  localparam logic [1:0] W2 = 2'd2;
  localparam logic [1:0] W1 = 2'd1;

  typedef logic [1:0] tpiu_state_t;
  localparam tpiu_state_t FSYNC = 2'd0;
  localparam tpiu_state_t HSYNC = 2'd1;
  localparam tpiu_state_t FRAME = 2'd2;

  // Pin lanes in use for a width code (0 behaves as 1-bit).
  function automatic logic [2:0] lane_bits(input logic [1:0] width);
    case (width)
      W4:      lane_bits = 3'd4;
      W2:      lane_bits = 3'd2;
      W1:      lane_bits = 3'd1;
      default: lane_bits = 3'd1;
    endcase
  endfunction

endpackage

// File: rtl/tpiu_tx_shifter.sv
// Variable-rate unit shifter: emits 2w bits per cycle (A lanes then B lanes), LSB first.
module tpiu_tx_shifter
  import tpiu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [1:0]         width,
  input  logic [FRAME_W-1:0] load_data,
  input  logic [REM_W-1:0]   load_bits,
  output logic [3:0]         douta,
  output logic [3:0]         doutb,
  output logic               busy,
  output logic               last,
  output logic               pre_last
);

  logic [FRAME_W-1:0] sreg;
  logic [REM_W-1:0]   rem;
  logic [1:0]         width_q;
  logic [2:0]         w_c;
  logic [2:0]         cur_w_c;
  logic [3:0]         step_c;
  logic [3:0]         mask_c;
  logic [FRAME_W-1:0] src_c;

  // Select the word and lane width feeding the pins this cycle; flag the unit's final cycles.
  always_comb begin
    cur_w_c  = lane_bits(width_q);
    w_c      = load ? lane_bits(width) : cur_w_c;
    step_c   = 4'({w_c, 1'b0});
    mask_c   = 4'((5'd1 << w_c) - 5'd1);
    src_c    = load ? load_data : sreg;
    busy     = (rem != '0);
    last     = (rem == {4'b0, cur_w_c, 1'b0});
    pre_last = (rem == {3'b0, cur_w_c, 2'b0});
  end

  // Register pin lanes and advance the shift register / remaining-bit count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg    <= '0;
      rem     <= '0;
      width_q <= W1;
      douta   <= '0;
      doutb   <= '0;
    end else if (load || busy) begin
      douta <= src_c[3:0] & mask_c;
      doutb <= 4'(src_c >> w_c) & mask_c;
      sreg  <= src_c >> step_c;
      if (load) begin
        rem     <= load_bits;
        width_q <= width;
      end else begin
        rem <= rem - REM_W'(step_c);
      end
    end
  end

endmodule

// File: rtl/tpiu_tx.sv
// TPIU transmit formatter: schedules full syncs, frames and halfsyncs onto a DDR trace port.
module tpiu_tx
  import tpiu_pkg::*;
#(
  parameter int unsigned SYNC_INTERVAL = 8,
  parameter int unsigned STARTUP_SYNCS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         width,
  input  logic               PkAvail,
  input  logic [FRAME_W-1:0] Packet,
  output logic               PkTaken,
  output logic [3:0]         traceDouta,
  output logic [3:0]         traceDoutb,
  output logic               syncOut,
  output logic               idle
);

  localparam int unsigned FCNT_W = (SYNC_INTERVAL == 0) ? 1 : $clog2(SYNC_INTERVAL + 1);
  localparam int unsigned SCNT_W = 3;

  tpiu_state_t         nxt_q;
  tpiu_state_t         dec_c;
  logic                take_c;
  logic                sync_due_c;
  logic                load_c;
  logic [SCNT_W-1:0]   start_cnt;
  logic [FCNT_W-1:0]   frame_cnt;
  logic [FRAME_W-1:0]  ld_data_c;
  logic [REM_W-1:0]    ld_bits_c;
  logic                busy;
  logic                last;
  logic                pre_last;

  // Next-unit priority: startup syncs, forced periodic sync, frame, then halfsync filler.
  always_comb begin
    dec_c      = HSYNC;
    take_c     = 1'b0;
    sync_due_c = (SYNC_INTERVAL != 0) && (frame_cnt == FCNT_W'(SYNC_INTERVAL));
    if (start_cnt != '0) begin
      dec_c = FSYNC;
    end else if (sync_due_c) begin
      dec_c = FSYNC;
    end else if (PkAvail) begin
      dec_c  = FRAME;
      take_c = 1'b1;
    end
    load_c = last || !busy;
    case (nxt_q)
      FSYNC: begin
        ld_data_c = FRAME_W'(FSYNC_WORD);
        ld_bits_c = REM_W'(32);
      end
      HSYNC: begin
        ld_data_c = FRAME_W'(HSYNC_WORD);
        ld_bits_c = REM_W'(16);
      end
      default: begin
        ld_data_c = Packet;
        ld_bits_c = REM_W'(128);
      end
    endcase
  end

  // Decide one cycle early so PkTaken lands in the last cycle of the current unit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nxt_q   <= FSYNC;
      PkTaken <= 1'b0;
    end else begin
      PkTaken <= pre_last && take_c;
      if (pre_last) nxt_q <= dec_c;
    end
  end

  // Unit-start bookkeeping: sync/idle flags and startup/frame counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_cnt <= SCNT_W'(STARTUP_SYNCS);
      frame_cnt <= '0;
      syncOut   <= 1'b0;
      idle      <= 1'b0;
    end else begin
      syncOut <= load_c && (nxt_q == FSYNC);
      if (load_c) begin
        idle <= (nxt_q == HSYNC);
        if (nxt_q == FSYNC) begin
          frame_cnt <= '0;
          if (start_cnt != '0) start_cnt <= start_cnt - SCNT_W'(1);
        end else if (nxt_q == FRAME && SYNC_INTERVAL != 0 &&
                     frame_cnt != FCNT_W'(SYNC_INTERVAL)) begin
          frame_cnt <= frame_cnt + FCNT_W'(1);
        end
      end
    end
  end

  tpiu_tx_shifter u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (load_c),
    .width     (width),
    .load_data (ld_data_c),
    .load_bits (ld_bits_c),
    .douta     (traceDouta),
    .doutb     (traceDoutb),
    .busy      (busy),
    .last      (last),
    .pre_last  (pre_last)
  );

endmodule
